svpwm_gate_decoder: RTL and testbench
=====================================

Name: svpwm_gate_decoder

Overview:
- Monitors the 6-bit gate bus produced by the SVPWM generator and decodes it back into the applied space vector, the sector, and the electrical period.
- Measures per-leg dead time and flags short dead time and illegal vector sequences.
- Sits beside the generator and motor-driver pins as a self-check and telemetry block; it feeds the status/debug interface.

Parameters:
- MIN_DEAD_CYC, 2: minimum legal dead time, in clk cycles.
- DEAD_W, 8: width of the dead-time counters and of dead_min.
- PERIOD_W, 24: width of the electrical-period counter and of period_cycles.

Ports:
- clk  in  1  system clock, 50 MHz.
- active  in  1  asynchronous active-low reset; low clears all state.
- s_in  in  6  gate bus. s_in[2:0] = top (inverted) legs A,B,C; s_in[5:3] = bottom legs A,B,C.
- clr_fault  in  1  synchronous clear of the sticky faults.
- vec  out  3  last valid decoded vector {A,B,C}.
- vec_valid  out  1  high while all three legs decode to valid levels.
- sector  out  3  decoded sector 1..6; 0 = unknown.
- sector_valid  out  1  sector is locked.
- period_cycles  out  PERIOD_W  last measured electrical period, in cycles.
- period_strobe  out  1  one-cycle pulse when period_cycles updates.
- dead_min  out  DEAD_W  smallest dead time measured since reset or clr_fault.
- dead_fault  out  1  sticky; a dead interval shorter than MIN_DEAD_CYC occurred.
- seq_fault  out  1  sticky; an illegal vector sequence or sector step occurred.
- legs_off  out  1  all legs in the OFF code.

Behaviour:
- Reset values: every output and internal register is 0, except dead_min, which resets to all-ones.
- Leg code per leg x is {s_in[x], s_in[3+x]}:
  - 01 = bit 1
  - 10 = bit 0
  - 00 = DEAD
  - 11 = OFF
- All outputs are registered. vec and vec_valid follow s_in with 1-cycle latency.
- When all legs decode valid, vec takes the decoded value. vec holds its last value while vec_valid is 0.
- Dead timing, per leg:
  - The counter increments while the leg is DEAD and saturates at 2^DEAD_W-1.
  - On the DEAD→valid exit, the count is compared. If count < MIN_DEAD_CYC, set dead_fault. Update dead_min = min(dead_min, count).
  - A DEAD→OFF exit is not measured.
- Sequence FSM states: UNLOCKED, ZERO, ACT1, ACT2, SEVEN, DESC.
  - The FSM advances only on a change of the valid vector (new vec differs from previous vec).
  - UNLOCKED: on V0 (000) → ZERO.
  - ZERO: on an active vector (nonzero, not 111), capture a1 → ACT1. On 111 → seq_fault, UNLOCKED.
  - ACT1: on an active vector adjacent to a1, capture a2 → ACT2. Anything else → seq_fault, UNLOCKED.
  - ACT2: on 111 → SEVEN. Anything else → seq_fault, UNLOCKED.
  - Pair lookup (unordered):
    - {100,110} = 1
    - {010,110} = 2
    - {010,011} = 3
    - {001,011} = 4
    - {001,101} = 5
    - {100,101} = 6
  - SEVEN and DESC: an active vector in {a1,a2} → DESC. On V0 → ZERO. Any other vector → seq_fault, UNLOCKED.
  - On SEVEN entry, the pair sector is evaluated:
    - If sector_valid=0: load sector, set sector_valid=1.
    - Otherwise the new sector must equal sector or sector+1 (6 wraps to 1). Else set seq_fault, clear sector_valid and sector, go UNLOCKED.
- Period measurement:
  - A free counter saturates at 2^PERIOD_W-1.
  - On a locked 6→1 sector step: if a previous 6→1 step has been seen since lock, period_cycles ← counter and period_strobe=1 for one cycle. The counter then restarts at 1.
  - The first 6→1 step after lock only restarts the counter; no strobe.
- OFF handling:
  - legs_off=1 when all three legs are OFF.
  - Any leg OFF forces UNLOCKED, sector_valid=0, sector=0, and vec_valid=0.
  - Faults are not set by OFF.
- Faults:
  - clr_fault clears dead_fault and seq_fault, and resets dead_min to all-ones.
  - A fault event in the same cycle as clr_fault leaves the fault set.
- active low mid-operation clears everything asynchronously. After release, the FSM restarts from UNLOCKED.

Optional Feature:
- GATE_SYNC_EN defined: s_in passes through a 2-flop synchronizer before decode. All latencies increase by 2 cycles.
- Undefined: s_in is decoded directly (same clock domain as the generator).

Test Plan:
- Reset and clean decode: active=0, then 1, with s_in=6'b000_111 (V0) → after 1 cycle, vec=000, vec_valid=1, sector=0, faults 0.
- Sector 1 sequence: V0→V1→V2→V7→V2→V1→V0, each vector held 10 cycles with 3-cycle DEAD legs between changes → sector=1, sector_valid=1, dead_min=3, dead_fault=0.
- Period: run sectors 1..6 repeatedly, each sector lasting 1000 cycles → the second 6→1 step gives period_strobe pulse with period_cycles=6000; no strobe on the first.
- Short dead time: one leg DEAD for 1 cycle with MIN_DEAD_CYC=2 → dead_fault=1 and dead_min=1. clr_fault pulse → dead_fault=0 and dead_min=all-ones.
- Illegal steps: V0→V1→V4 → seq_fault=1, sector_valid=0. Also a locked sector 2 followed by a sector-4 pair → seq_fault=1.
- OFF and mid-run reset: s_in=6'b111_111 → legs_off=1, sector=0, no fault. Assert active=0 mid-sequence → all outputs 0 immediately; relock on the next V0.

Source files
------------

// File: rtl/svpwm_gate_decoder.sv
// svpwm_gate_decoder: decodes the SVPWM gate bus into vector, sector and electrical period; checks dead time and sequence.
// Latency: all outputs registered, 1 cycle from s_in (3 cycles when GATE_SYNC_EN adds a 2-flop input synchronizer).
// Backpressure: none, passive monitor; observes every cycle and never stalls the generator.
module svpwm_gate_decoder #(
  parameter int MIN_DEAD_CYC = 2,
  parameter int DEAD_W       = 8,
  parameter int PERIOD_W     = 24
) (
  input  logic                clk,
  input  logic                active,
  input  logic [5:0]          s_in,
  input  logic                clr_fault,
  output logic [2:0]          vec,
  output logic                vec_valid,
  output logic [2:0]          sector,
  output logic                sector_valid,
  output logic [PERIOD_W-1:0] period_cycles,
  output logic                period_strobe,
  output logic [DEAD_W-1:0]   dead_min,
  output logic                dead_fault,
  output logic                seq_fault,
  output logic                legs_off
);

  typedef enum logic [2:0] {
    ST_UNLOCKED, ST_ZERO, ST_ACT1, ST_ACT2, ST_SEVEN, ST_DESC
  } state_t;

  localparam logic [DEAD_W-1:0] MIN_DEAD = DEAD_W'(MIN_DEAD_CYC);
  localparam logic [2:0]        V0       = 3'b000;
  localparam logic [2:0]        V7       = 3'b111;

  // Sector formed by two adjacent active vectors (order-independent); 0 when not a legal pair.
  function automatic logic [2:0] pair_sector(input logic [2:0] p, input logic [2:0] q);
    logic [2:0] s;
    case ({p, q})
      6'b100_110, 6'b110_100: s = 3'd1;
      6'b010_110, 6'b110_010: s = 3'd2;
      6'b010_011, 6'b011_010: s = 3'd3;
      6'b001_011, 6'b011_001: s = 3'd4;
      6'b001_101, 6'b101_001: s = 3'd5;
      6'b100_101, 6'b101_100: s = 3'd6;
      default:                s = 3'd0;
    endcase
    return s;
  endfunction

  logic [5:0] gate;

`ifdef GATE_SYNC_EN
  logic [5:0] sync1_q, sync2_q;

  // Two-flop synchronizer for a gate bus coming from another clock domain.
  always_ff @(posedge clk or negedge active) begin
    if (!active) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= s_in;
      sync2_q <= sync1_q;
    end
  end
  assign gate = sync2_q;
`else
  assign gate = s_in;
`endif

  // Per-leg code {top, bottom}: 01 -> bit 1, 10 -> bit 0, 00 -> DEAD, 11 -> OFF.
  logic [2:0] leg_valid, leg_dead, leg_off, dec_vec;
  logic       all_valid, any_off, is_active, vec_change;

  assign leg_valid  = gate[2:0] ^ gate[5:3];
  assign leg_dead   = ~(gate[2:0] | gate[5:3]);
  assign leg_off    = gate[2:0] & gate[5:3];
  assign dec_vec    = {gate[3], gate[4], gate[5]};   // {A,B,C}: bottom switch on means bit 1
  assign all_valid  = &leg_valid;
  assign any_off    = |leg_off;
  assign is_active  = (dec_vec != V0) && (dec_vec != V7);

  // Registered state
  state_t                 state_q, state_d;
  logic [2:0]             vec_q, a1_q, a1_d, a2_q, a2_d;
  logic                   vec_valid_q, legs_off_q;
  logic [2:0]             sector_q, sector_d;
  logic                   sector_valid_q, sector_valid_d;
  logic                   step_seen_q, step_seen_d;
  logic [PERIOD_W-1:0]    pcnt_q, pcnt_d, period_q, period_d;
  logic                   strobe_q, strobe_d;
  logic [2:0][DEAD_W-1:0] dcnt_q, dcnt_d;
  logic [DEAD_W-1:0]      dead_min_q, dead_min_d, meas_min;
  logic                   dead_fault_q, dead_fault_d, dead_evt;
  logic                   seq_fault_q, seq_fault_d, seq_evt;
  logic [2:0]             new_sec, sec_next;

  assign vec_change = all_valid && (dec_vec != vec_q);
  assign new_sec    = pair_sector(a1_q, a2_q);
  assign sec_next   = (sector_q == 3'd6) ? 3'd1 : sector_q + 3'd1;

  // Dead-time counters: count while DEAD, measure on the DEAD->valid exit, track the minimum.
  always_comb begin
    dead_evt = 1'b0;
    meas_min = '1;
    for (int x = 0; x < 3; x++) begin
      dcnt_d[x] = '0;
      if (leg_dead[x]) begin
        dcnt_d[x] = (&dcnt_q[x]) ? dcnt_q[x] : dcnt_q[x] + DEAD_W'(1);
      end
      if (leg_valid[x] && (dcnt_q[x] != '0)) begin
        if (dcnt_q[x] < MIN_DEAD) dead_evt = 1'b1;
        if (dcnt_q[x] < meas_min) meas_min = dcnt_q[x];
      end
    end
    dead_min_d = clr_fault ? '1 : dead_min_q;
    if (meas_min < dead_min_d) dead_min_d = meas_min;
    dead_fault_d = (dead_fault_q & ~clr_fault) | dead_evt;
  end

  // Sequence FSM, sector lock and period measurement; moves only on a change of the valid vector.
  always_comb begin
    state_d        = state_q;
    a1_d           = a1_q;
    a2_d           = a2_q;
    sector_d       = sector_q;
    sector_valid_d = sector_valid_q;
    step_seen_d    = step_seen_q;
    period_d       = period_q;
    strobe_d       = 1'b0;
    seq_evt        = 1'b0;
    pcnt_d         = (&pcnt_q) ? pcnt_q : pcnt_q + PERIOD_W'(1);

    if (any_off) begin
      // Driver disabled: drop lock silently, no fault.
      state_d        = ST_UNLOCKED;
      sector_d       = 3'd0;
      sector_valid_d = 1'b0;
      step_seen_d    = 1'b0;
    end else if (all_valid) begin
      case (state_q)
        ST_UNLOCKED: begin
          // Level-sensitive so a held V0 after reset or OFF relocks without a vector change.
          if (dec_vec == V0) state_d = ST_ZERO;
        end
        ST_ZERO: begin
          if (vec_change) begin
            if (is_active) begin
              a1_d    = dec_vec;
              state_d = ST_ACT1;
            end else if (dec_vec == V7) begin
              seq_evt = 1'b1;
            end
          end
        end
        ST_ACT1: begin
          if (vec_change) begin
            if (is_active && (pair_sector(a1_q, dec_vec) != 3'd0)) begin
              a2_d    = dec_vec;
              state_d = ST_ACT2;
            end else begin
              seq_evt = 1'b1;
            end
          end
        end
        ST_ACT2: begin
          if (vec_change) begin
            if (dec_vec == V7) begin
              state_d = ST_SEVEN;
              if (!sector_valid_q) begin
                sector_d       = new_sec;
                sector_valid_d = 1'b1;
              end else if (new_sec == sec_next) begin
                sector_d = new_sec;
                if (sector_q == 3'd6) begin
                  // 6->1 wrap: one electrical period boundary; the first one only arms the counter.
                  if (step_seen_q) begin
                    period_d = pcnt_q;
                    strobe_d = 1'b1;
                  end
                  step_seen_d = 1'b1;
                  pcnt_d      = PERIOD_W'(1);
                end
              end else if (new_sec != sector_q) begin
                seq_evt = 1'b1;
              end
            end else begin
              seq_evt = 1'b1;
            end
          end
        end
        ST_SEVEN, ST_DESC: begin
          if (vec_change) begin
            if (is_active && ((dec_vec == a1_q) || (dec_vec == a2_q))) state_d = ST_DESC;
            else if (dec_vec == V0)                                     state_d = ST_ZERO;
            else                                                        seq_evt = 1'b1;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase

      if (seq_evt) begin
        state_d        = ST_UNLOCKED;
        sector_d       = 3'd0;
        sector_valid_d = 1'b0;
        step_seen_d    = 1'b0;
      end
    end

    seq_fault_d = (seq_fault_q & ~clr_fault) | seq_evt;
  end

  // State registers; dead_min resets to all-ones so the first measurement always lands.
  always_ff @(posedge clk or negedge active) begin
    if (!active) begin
      state_q        <= ST_UNLOCKED;
      vec_q          <= '0;
      vec_valid_q    <= 1'b0;
      legs_off_q     <= 1'b0;
      a1_q           <= '0;
      a2_q           <= '0;
      sector_q       <= '0;
      sector_valid_q <= 1'b0;
      step_seen_q    <= 1'b0;
      pcnt_q         <= '0;
      period_q       <= '0;
      strobe_q       <= 1'b0;
      dcnt_q         <= '0;
      dead_min_q     <= '1;
      dead_fault_q   <= 1'b0;
      seq_fault_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      vec_q          <= all_valid ? dec_vec : vec_q;
      vec_valid_q    <= all_valid;
      legs_off_q     <= &leg_off;
      a1_q           <= a1_d;
      a2_q           <= a2_d;
      sector_q       <= sector_d;
      sector_valid_q <= sector_valid_d;
      step_seen_q    <= step_seen_d;
      pcnt_q         <= pcnt_d;
      period_q       <= period_d;
      strobe_q       <= strobe_d;
      dcnt_q         <= dcnt_d;
      dead_min_q     <= dead_min_d;
      dead_fault_q   <= dead_fault_d;
      seq_fault_q    <= seq_fault_d;
    end
  end

  assign vec           = vec_q;
  assign vec_valid     = vec_valid_q;
  assign sector        = sector_q;
  assign sector_valid  = sector_valid_q;
  assign period_cycles = period_q;
  assign period_strobe = strobe_q;
  assign dead_min      = dead_min_q;
  assign dead_fault    = dead_fault_q;
  assign seq_fault     = seq_fault_q;
  assign legs_off      = legs_off_q;

endmodule

// File: tb/tb_svpwm_gate_decoder.sv
// Bench for svpwm_gate_decoder: directed gate-bus sequences, a behavioural reference model
// compared every cycle, and hand-computed literal expectations at key points.
module tb_svpwm_gate_decoder;

  localparam int MIN_DEAD = 2;
  localparam int DMAX     = 255;
  localparam int PMAX     = 16777215;

  logic        clk = 1'b0;
  logic        active;
  logic [5:0]  s_in;
  logic        clr_fault;
  logic [2:0]  vec;
  logic        vec_valid;
  logic [2:0]  sector;
  logic        sector_valid;
  logic [23:0] period_cycles;
  logic        period_strobe;
  logic [7:0]  dead_min;
  logic        dead_fault;
  logic        seq_fault;
  logic        legs_off;

  svpwm_gate_decoder #(.MIN_DEAD_CYC(2), .DEAD_W(8), .PERIOD_W(24)) dut (
    .clk(clk), .active(active), .s_in(s_in), .clr_fault(clr_fault),
    .vec(vec), .vec_valid(vec_valid), .sector(sector), .sector_valid(sector_valid),
    .period_cycles(period_cycles), .period_strobe(period_strobe),
    .dead_min(dead_min), .dead_fault(dead_fault), .seq_fault(seq_fault), .legs_off(legs_off)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_strobe = 0;
  logic run_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Legal adjacent pairs; index+1 is the sector.
  int pr_a[6] = '{4, 2, 2, 1, 1, 4};
  int pr_b[6] = '{6, 6, 3, 3, 5, 5};

  function automatic int pair_sec(input int p, input int q);
    for (int i = 0; i < 6; i++)
      if ((p == pr_a[i] && q == pr_b[i]) || (p == pr_b[i] && q == pr_a[i])) return i + 1;
    return 0;
  endfunction

  int   e_vec, e_sector, e_period, e_dmin;
  logic e_vv, e_sv, e_strobe, e_df, e_sf, e_off;
  logic locked, wrap_seen;
  int   seg[$];          // distinct vectors seen since the last V0
  int   dlen[3];
  int   cyc, wrap_cyc;

  task automatic model_reset();
    e_vec = 0; e_vv = 0; e_sector = 0; e_sv = 0; e_period = 0; e_strobe = 0;
    e_dmin = DMAX; e_df = 0; e_sf = 0; e_off = 0;
    locked = 0; wrap_seen = 0; seg.delete(); cyc = 0; wrap_cyc = 0;
    for (int x = 0; x < 3; x++) dlen[x] = 0;
  endtask

  task automatic model_step();
    logic [2:0] lv, loff;
    logic dev, lose;
    int meas, v, n, s;
    cyc++;
    dev = 0; lose = 0; meas = DMAX;
    for (int x = 0; x < 3; x++) begin
      lv[x]   = (s_in[x] != s_in[3+x]);
      loff[x] = s_in[x] && s_in[3+x];
      if (lv[x] && dlen[x] > 0) begin
        if (dlen[x] < MIN_DEAD) dev = 1;
        if (dlen[x] < meas) meas = dlen[x];
      end
      if (!s_in[x] && !s_in[3+x]) dlen[x] = (dlen[x] < DMAX) ? dlen[x] + 1 : DMAX;
      else dlen[x] = 0;
    end
    if (clr_fault) e_dmin = DMAX;
    if (meas < e_dmin) e_dmin = meas;
    e_df = (e_df && !clr_fault) || dev;

    v = {s_in[3], s_in[4], s_in[5]};
    e_strobe = 0;
    if (|loff) begin
      locked = 0; e_sector = 0; e_sv = 0; wrap_seen = 0;
    end else if (&lv) begin
      if (!locked) begin
        if (v == 0) begin locked = 1; seg.delete(); end
      end else if (v != e_vec) begin
        n = seg.size();
        if (n == 0) begin
          if (v == 7) lose = 1; else if (v != 0) seg.push_back(v);
        end else if (n == 1) begin
          if (pair_sec(seg[0], v) != 0) seg.push_back(v); else lose = 1;
        end else if (n == 2) begin
          if (v != 7) lose = 1;
          else begin
            seg.push_back(v);
            s = pair_sec(seg[0], seg[1]);
            if (!e_sv) begin e_sector = s; e_sv = 1; end
            else if (s == e_sector % 6 + 1) begin
              if (e_sector == 6) begin
                if (wrap_seen) begin
                  e_period = (cyc - wrap_cyc > PMAX) ? PMAX : cyc - wrap_cyc;
                  e_strobe = 1;
                end
                wrap_seen = 1; wrap_cyc = cyc;
              end
              e_sector = s;
            end else if (s != e_sector) lose = 1;
          end
        end else begin
          if (v == 0) seg.delete();
          else if (v != seg[0] && v != seg[1]) lose = 1;
        end
        if (lose) begin locked = 0; e_sector = 0; e_sv = 0; wrap_seen = 0; end
      end
    end
    e_sf = (e_sf && !clr_fault) || lose;
    if (&lv) e_vec = v;
    e_vv  = &lv;
    e_off = &loff;
  endtask

  always @(posedge clk or negedge active) begin
    if (!active) model_reset();
    else         model_step();
  end

  // Cycle-by-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (active === 1'b1 && run_chk) begin
      chk("vec",           vec,           e_vec);
      chk("vec_valid",     vec_valid,     e_vv);
      chk("sector",        sector,        e_sector);
      chk("sector_valid",  sector_valid,  e_sv);
      chk("period_cycles", period_cycles, e_period);
      chk("period_strobe", period_strobe, e_strobe);
      chk("dead_min",      dead_min,      e_dmin);
      chk("dead_fault",    dead_fault,    e_df);
      chk("seq_fault",     seq_fault,     e_sf);
      chk("legs_off",      legs_off,      e_off);
      if (period_strobe === 1'b1) n_strobe++;
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0] cur;
  logic [2:0] sa1[6] = '{3'd4, 3'd6, 3'd2, 3'd3, 3'd1, 3'd5};
  logic [2:0] sa2[6] = '{3'd6, 3'd2, 3'd3, 3'd1, 3'd5, 3'd4};

  // Gate bus for vector v with legs in dm (bit x = leg x) forced DEAD.
  function automatic logic [5:0] enc(input logic [2:0] v, input logic [2:0] dm);
    logic [5:0] s;
    for (int x = 0; x < 3; x++) begin
      if (dm[x]) begin s[x] = 1'b0; s[3+x] = 1'b0; end
      else begin s[x] = ~v[2-x]; s[3+x] = v[2-x]; end
    end
    return s;
  endfunction

  task automatic hold(input logic [5:0] s, input int n);
    s_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [2:0] to, input int dead, input int n);
    logic [2:0] diff, dm;
    diff = cur ^ to;
    dm = {diff[0], diff[1], diff[2]};
    if (dead > 0) hold(enc(cur, dm), dead);
    hold(enc(to, 3'b000), n);
    cur = to;
  endtask

  // Full symmetric sequence V0->a1->a2->V7->a2->a1->V0 for sector k (1..6).
  task automatic sector_run(input int k, input int h, input int hlast);
    go(sa1[k-1], 3, h);
    go(sa2[k-1], 3, h);
    go(3'd7,     3, h);
    go(sa2[k-1], 3, h);
    go(sa1[k-1], 3, h);
    go(3'd0,     3, hlast);
  endtask

  task automatic clr_pulse();
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
  endtask

  initial begin
    active = 1'b0; clr_fault = 1'b0; cur = 3'd0;
    s_in = enc(3'd0, 3'b000);
    @(negedge clk);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_sector", sector, 0);
    chk("rst_dead_min", dead_min, 255);
    chk("rst_faults", {dead_fault, seq_fault}, 0);
    active = 1'b1; run_chk = 1'b1;
    @(negedge clk);
    chk("v0_vec", vec, 0);
    chk("v0_vec_valid", vec_valid, 1);
    chk("v0_sector", sector, 0);
    hold(enc(3'd0, 3'b000), 3);

    // Sector 1, 3-cycle dead intervals.
    sector_run(1, 10, 10);
    chk("s1_sector", sector, 1);
    chk("s1_sector_valid", sector_valid, 1);
    chk("s1_dead_min", dead_min, 3);
    chk("s1_dead_fault", dead_fault, 0);

    // Period: two rounds of sectors 2..6,1 at 1000 cycles each.
    for (int r = 0; r < 2; r++) begin
      for (int k = 2; k <= 6; k++) sector_run(k, 160, 182);
      sector_run(1, 160, 182);
      if (r == 0) chk("first_wrap_strobes", n_strobe, 0);
    end
    chk("second_wrap_strobes", n_strobe, 1);
    chk("period_cycles", period_cycles, 6000);
    chk("model_period", e_period, 6000);

    // Short dead time on leg A.
    go(3'd4, 1, 10);
    chk("short_dead_fault", dead_fault, 1);
    chk("short_dead_min", dead_min, 1);
    go(3'd6, 3, 10);
    go(3'd7, 3, 10);
    go(3'd0, 3, 10);
    chk("short_no_seq", seq_fault, 0);
    clr_pulse();
    chk("clr_dead_fault", dead_fault, 0);
    chk("clr_dead_min", dead_min, 255);

    // Illegal step V0 -> V1 (100) -> V4 (011).
    go(3'd4, 3, 10);
    go(3'd3, 3, 10);
    chk("illegal_seq_fault", seq_fault, 1);
    chk("illegal_sector_valid", sector_valid, 0);
    go(3'd0, 3, 10);
    clr_pulse();

    // Locked sector 2, then a sector-4 pair.
    sector_run(2, 10, 10);
    chk("s2_sector", sector, 2);
    chk("s2_seq_fault", seq_fault, 0);
    go(3'd3, 3, 10);
    go(3'd1, 3, 10);
    go(3'd7, 3, 10);
    chk("jump_seq_fault", seq_fault, 1);
    chk("jump_sector_valid", sector_valid, 0);
    go(3'd0, 3, 10);
    clr_pulse();

    // OFF after a lock.
    sector_run(1, 10, 10);
    chk("pre_off_sector", sector, 1);
    hold(6'b111111, 5);
    chk("off_legs_off", legs_off, 1);
    chk("off_sector", sector, 0);
    chk("off_vec_valid", vec_valid, 0);
    chk("off_faults", {dead_fault, seq_fault}, 0);
    hold(enc(3'd0, 3'b000), 5);
    cur = 3'd0;

    // Asynchronous reset mid-sequence.
    go(3'd4, 3, 10);
    go(3'd6, 3, 5);
    #3;
    active = 1'b0;
    #1;
    chk("areset_vec", vec, 0);
    chk("areset_vec_valid", vec_valid, 0);
    chk("areset_sector", {sector_valid, sector}, 0);
    chk("areset_dead_min", dead_min, 255);
    chk("areset_period", {period_strobe, period_cycles}, 0);
    @(negedge clk);
    active = 1'b1;
    cur = 3'd0;
    hold(enc(3'd0, 3'b000), 4);
    chk("relock_vec_valid", vec_valid, 1);
    sector_run(1, 10, 10);
    chk("relock_sector", sector, 1);
    chk("relock_sector_valid", sector_valid, 1);

    run_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
